// File: rtl/dmr_stream_join.sv
// Joins NUM_IN redundant streams into one, flagging mismatches and skew timeouts.
// Latency: 1 cycle from matching input beat to valid_o (single output register).
// Backpressure: matching beats wait for a free output stage; mismatches and timeouts are always consumed.
module dmr_stream_join #(
  parameter type T        = logic,
  parameter int  NUM_IN   = 2,
  parameter int  MAX_SKEW = 4,
  parameter int  CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_IN-1:0] valid_i,
  output logic [NUM_IN-1:0] ready_o,
  input  T                  data_i [NUM_IN],
  output logic              valid_o,
  input  logic              ready_i,
  output T                  data_o,
  output logic              error_o,
  output logic              repeat_o,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  localparam int SW = $clog2(MAX_SKEW + 1);

  typedef enum logic {ALIGNED, SKEWED} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   skew_cnt_q, skew_cnt_d;
  logic            full_q;
  T                data_q;
  logic            repeat_q;
  logic [CNT_W-1:0] fault_cnt_q;

  logic all_v, none_v, part_v, eq, free, accept, timeout, mismatch;

  assign all_v    = &valid_i;
  assign none_v   = ~|valid_i;
  assign part_v   = !all_v && !none_v;
  assign free     = !full_q || ready_i;
  assign mismatch = all_v && !eq;

  // Full-width payload comparison of every source against source 0
  always_comb begin
    eq = 1'b1;
    for (int k = 1; k < NUM_IN; k++) begin
      if (data_i[k] != data_i[0]) eq = 1'b0;
    end
  end

  // Skew FSM next state: count partially valid cycles, give up after MAX_SKEW of them
  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    timeout    = 1'b0;
    case (state_q)
      ALIGNED: begin
        if (part_v) begin
          state_d    = SKEWED;
          skew_cnt_d = SW'(1);
        end
      end
      SKEWED: begin
        if (!part_v) begin
          state_d    = ALIGNED;
          skew_cnt_d = '0;
        end else if (skew_cnt_q == SW'(MAX_SKEW)) begin
          timeout    = 1'b1;
          state_d    = ALIGNED;
          skew_cnt_d = '0;
        end else begin
          skew_cnt_d = skew_cnt_q + SW'(1);
        end
      end
      default: begin
        state_d    = ALIGNED;
        skew_cnt_d = '0;
      end
    endcase
  end

  // Handshake decode: matches wait for space, mismatches flush, timeouts drop only offered beats
  always_comb begin
    ready_o = '0;
    accept  = 1'b0;
    error_o = 1'b0;
    if (all_v) begin
      if (!eq) begin
        ready_o = '1;
        error_o = 1'b1;
      end else if (free) begin
        ready_o = '1;
        accept  = 1'b1;
      end
    end else if (timeout) begin
      ready_o = valid_i;
      error_o = 1'b1;
    end
  end

  // Skew FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ALIGNED;
      skew_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
    end
  end

  // Output stage: load on accept, empty on downstream handshake without a refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        full_q <= 1'b1;
        data_q <= data_i[0];
      end else if (ready_i) begin
        full_q <= 1'b0;
      end
    end
  end

  // Fault reporting: one-cycle repeat request and saturating fault counter, clear wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      repeat_q    <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      repeat_q <= error_o;
      if (clear_i) begin
        fault_cnt_q <= '0;
      end else if (error_o && (fault_cnt_q != {CNT_W{1'b1}})) begin
        fault_cnt_q <= fault_cnt_q + CNT_W'(1);
      end
    end
  end

  assign valid_o     = full_q;
  assign data_o      = data_q;
  assign repeat_o    = repeat_q;
  assign fault_cnt_o = fault_cnt_q;

  // mismatch is kept as a readable alias of the all-valid-but-different condition
  logic unused_mismatch;
  assign unused_mismatch = mismatch;

endmodule

// File: tb/tb_dmr_stream_join.sv
module tb_dmr_stream_join;

  logic       clk;
  logic       rst_n;
  logic [1:0] vld;
  logic [1:0] rdy_o;
  logic [7:0] din [2];
  logic       vo;
  logic       rdy_i;
  logic [7:0] dout;
  logic       err;
  logic       rep;
  logic       clr;
  logic [1:0] cnt;

  int checks   = 0;
  int failures = 0;

  dmr_stream_join #(
    .T(logic [7:0]),
    .NUM_IN(2),
    .MAX_SKEW(4),
    .CNT_W(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .valid_i(vld),
    .ready_o(rdy_o),
    .data_i(din),
    .valid_o(vo),
    .ready_i(rdy_i),
    .data_o(dout),
    .error_o(err),
    .repeat_o(rep),
    .clear_i(clr),
    .fault_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs for the row, then the outputs expected in that cycle (registered ones
  // reflect the rows before it).
  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       clr;
    logic [1:0] e_rdyo;
    logic       e_err;
    logic       e_vo;
    logic [7:0] e_do;
    logic       e_rep;
    logic [1:0] e_cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  initial begin
    //            v      d0     d1     rdy   clr   rdyo   err   vo    do     rep   cnt
    tbl[0]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{2'b11, 8'h5A, 8'h5A, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h5A, 1'b0, 2'd0};
    tbl[3]  = '{2'b11, 8'h5A, 8'h5B, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h5A, 1'b0, 2'd0};
    tbl[4]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b1, 2'd1};
    tbl[5]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[6]  = '{2'b01, 8'h11, 8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[7]  = '{2'b01, 8'h11, 8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[8]  = '{2'b01, 8'h11, 8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[9]  = '{2'b01, 8'h11, 8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[10] = '{2'b01, 8'h11, 8'h22, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h5A, 1'b0, 2'd1};
    tbl[11] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b1, 2'd2};
    tbl[12] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd2};
    tbl[13] = '{2'b01, 8'h33, 8'h33, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd2};
    tbl[14] = '{2'b01, 8'h33, 8'h33, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd2};
    tbl[15] = '{2'b11, 8'h33, 8'h33, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 8'h5A, 1'b0, 2'd2};
    tbl[16] = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h33, 1'b0, 2'd2};
    tbl[17] = '{2'b11, 8'h44, 8'h44, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h33, 1'b0, 2'd2};
    tbl[18] = '{2'b11, 8'h44, 8'h44, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h33, 1'b0, 2'd2};
    tbl[19] = '{2'b11, 8'h44, 8'h44, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 8'h33, 1'b0, 2'd2};
    tbl[20] = '{2'b11, 8'h55, 8'h56, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 8'h44, 1'b0, 2'd2};
    tbl[21] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 8'h44, 1'b1, 2'd3};
    tbl[22] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h44, 1'b0, 2'd3};
    tbl[23] = '{2'b11, 8'h01, 8'h02, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h44, 1'b0, 2'd0};
    tbl[24] = '{2'b11, 8'h01, 8'h02, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h44, 1'b1, 2'd1};
    tbl[25] = '{2'b11, 8'h01, 8'h02, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h44, 1'b1, 2'd2};
    tbl[26] = '{2'b11, 8'h01, 8'h02, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 8'h44, 1'b1, 2'd3};
    tbl[27] = '{2'b11, 8'h01, 8'h02, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h44, 1'b1, 2'd3};
    tbl[28] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h44, 1'b1, 2'd0};
    tbl[29] = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h44, 1'b0, 2'd0};

    rst_n  = 1'b0;
    vld    = 2'b00;
    din[0] = 8'h00;
    din[1] = 8'h00;
    rdy_i  = 1'b1;
    clr    = 1'b0;

    // Reset state, before any clock edge
    #1;
    chk("reset valid_o", 32'(vo), 32'd0);
    chk("reset data_o", 32'(dout), 32'h00);
    chk("reset repeat_o", 32'(rep), 32'd0);
    chk("reset fault_cnt_o", 32'(cnt), 32'd0);
    chk("reset ready_o", 32'(rdy_o), 32'd0);
    chk("reset error_o", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      vld    = tbl[i].v;
      din[0] = tbl[i].d0;
      din[1] = tbl[i].d1;
      rdy_i  = tbl[i].rdy;
      clr    = tbl[i].clr;
      #1;
      chk($sformatf("row%0d ready_o", i), 32'(rdy_o), 32'(tbl[i].e_rdyo));
      chk($sformatf("row%0d error_o", i), 32'(err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d valid_o", i), 32'(vo), 32'(tbl[i].e_vo));
      chk($sformatf("row%0d data_o", i), 32'(dout), 32'(tbl[i].e_do));
      chk($sformatf("row%0d repeat_o", i), 32'(rep), 32'(tbl[i].e_rep));
      chk($sformatf("row%0d fault_cnt_o", i), 32'(cnt), 32'(tbl[i].e_cnt));
    end

    // Asynchronous reset mid-transfer: buffered beat, pending repeat, count and skew all dropped
    @(negedge clk);
    vld = 2'b11; din[0] = 8'hAA; din[1] = 8'hAA; rdy_i = 1'b0; clr = 1'b0;
    @(negedge clk);
    din[1] = 8'hAB;
    #1;
    chk("pre-reset error_o", 32'(err), 32'd1);
    chk("pre-reset valid_o", 32'(vo), 32'd1);
    chk("pre-reset data_o", 32'(dout), 32'hAA);
    @(negedge clk);
    vld = 2'b01; din[1] = 8'hAA;
    #1;
    chk("pre-reset repeat_o", 32'(rep), 32'd1);
    chk("pre-reset fault_cnt_o", 32'(cnt), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset valid_o", 32'(vo), 32'd0);
    chk("mid reset data_o", 32'(dout), 32'h00);
    chk("mid reset repeat_o", 32'(rep), 32'd0);
    chk("mid reset fault_cnt_o", 32'(cnt), 32'd0);
    chk("mid reset ready_o", 32'(rdy_o), 32'd0);

    // First edge after release operates normally
    @(negedge clk);
    rst_n = 1'b1;
    vld = 2'b11; din[0] = 8'hBB; din[1] = 8'hBB; rdy_i = 1'b1;
    #1;
    chk("post-reset ready_o", 32'(rdy_o), 32'b11);
    @(negedge clk);
    vld = 2'b01; din[1] = 8'hCC;
    #1;
    chk("post-reset valid_o", 32'(vo), 32'd1);
    chk("post-reset data_o", 32'(dout), 32'hBB);

    // Skew counter restarted from zero: timeout lands on the fifth partial cycle
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("skew%0d ready_o", i), 32'(rdy_o), (i == 4) ? 32'b01 : 32'b00);
      chk($sformatf("skew%0d error_o", i), 32'(err), (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    vld = 2'b00;
    #1;
    chk("skew repeat_o", 32'(rep), 32'd1);
    chk("skew fault_cnt_o", 32'(cnt), 32'd1);
    @(negedge clk);
    #1;
    chk("skew repeat_o drop", 32'(rep), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmr_stream_join.md
DMR_STREAM_JOIN -- requirements
Module: dmr_stream_join

Interface
REQ-001 Parameter T, default logic: payload type of every data port.
REQ-002 Parameter NUM_IN, default 2: number of redundant input streams, at least 2.
REQ-003 Parameter MAX_SKEW, default 4: maximum number of partially valid cycles tolerated, at least 1.
REQ-004 Parameter CNT_W, default 8: width of the fault counter.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 valid_i  in  NUM_IN  per-source valid.
REQ-008 ready_o  out  NUM_IN  per-source ready.
REQ-009 data_i  in  NUM_IN x T  per-source payload.
REQ-010 valid_o  out  1  joined output valid.
REQ-011 ready_i  in  1  downstream ready.
REQ-012 data_o  out  T  joined payload.
REQ-013 error_o  out  1  combinational fault indication for the current cycle.
REQ-014 repeat_o  out  1  registered one-cycle request for upstream re-execution.
REQ-015 clear_i  in  1  synchronous clear of fault_cnt_o.
REQ-016 fault_cnt_o  out  CNT_W  saturating count of detected faults.

Function
REQ-017 all_v SHALL mean every valid_i bit is 1; none_v SHALL mean every bit is 0; part_v SHALL mean neither holds.
REQ-018 eq SHALL mean every data_i[k] equals data_i[0], over the full T width.
REQ-019 The output stage SHALL be a single register (full_q, data_q); valid_o SHALL equal full_q and data_o SHALL equal data_q.
REQ-020 free SHALL mean !full_q || ready_i.
REQ-021 Match case: when all_v && eq && free, ready_o SHALL be all ones, data_q SHALL load data_i[0], and full_q SHALL be set.
REQ-022 Match case when the stage is not free: ready_o SHALL be all zeros and the inputs SHALL be held.
REQ-023 Input-to-output latency SHALL be exactly 1 cycle.
REQ-024 Mismatch case: when all_v && !eq, ready_o SHALL be all ones regardless of the output stage.
REQ-025 In the mismatch case, the beat SHALL be discarded, error_o SHALL be 1 that cycle, and no output beat SHALL be produced.
REQ-026 Skew FSM, state Aligned: part_v SHALL move it to Skewed with skew_cnt=1.
REQ-027 In Aligned, all_v or none_v SHALL keep the state.
REQ-028 Skew FSM, state Skewed: all_v or none_v SHALL return it to Aligned with skew_cnt=0, and all_v beats SHALL then follow REQ-021 to REQ-025.
REQ-029 In Skewed with part_v and skew_cnt<MAX_SKEW, skew_cnt SHALL increment and ready_o SHALL be all zeros.
REQ-030 Skew timeout: in Skewed with part_v and skew_cnt==MAX_SKEW, ready_o SHALL equal valid_i, dropping the offered beats.
REQ-031 On skew timeout, error_o SHALL be 1 and the FSM SHALL return to Aligned with skew_cnt=0.
REQ-032 While Aligned or Skewed without timeout and part_v, ready_o SHALL be all zeros.
REQ-033 Any cycle with error_o=1 SHALL set repeat_o to 1 in the following cycle only; back-to-back faults SHALL keep repeat_o high.
REQ-034 Each cycle with error_o=1 SHALL increment fault_cnt_o, saturating at all ones.
REQ-035 clear_i SHALL zero fault_cnt_o next cycle and SHALL take priority over a simultaneous increment.
REQ-036 Output handshake: when full_q && ready_i and no new accept occurs, full_q SHALL clear.
REQ-037 When an accept and an output handshake occur in the same cycle, full_q SHALL stay 1 with the new data.
REQ-038 ready_o SHALL never be asserted to a source whose valid_i is 0, except in the all_v cases.
REQ-039 data_o SHALL be stable while valid_o && !ready_i.

Reset
REQ-040 While rst_ni=0, independent of clk_i: full_q=0, data_q='0, valid_o=0, data_o='0.
REQ-041 While rst_ni=0: repeat_o=0, fault_cnt_o=0, skew FSM=Aligned, skew_cnt=0.
REQ-042 ready_o and error_o are combinational and SHALL follow from the reset state and current inputs.
REQ-043 Reset asserted mid-transfer SHALL drop any buffered beat.
REQ-044 After release, the first rising edge SHALL operate normally.

Verification
REQ-045 NUM_IN=2; both valid with data 0x5A, ready_i=1 -> ready_o=2'b11, valid_o=1 and data_o=0x5A next cycle, error_o=0.
REQ-046 Both valid with 0x5A/0x5B -> ready_o=2'b11, error_o=1, valid_o stays 0, repeat_o=1 for one cycle, fault_cnt_o=1.
REQ-047 valid_i=2'b01 held, MAX_SKEW=4 -> ready_o=0 for 4 cycles, then in the 5th cycle ready_o=2'b01, error_o=1, repeat_o=1 next cycle.
REQ-048 valid_i=2'b01 for 2 cycles, then 2'b11 with equal data -> no error, beat accepted, skew FSM back to Aligned.
REQ-049 Output full and ready_i=0 with a matching pair offered -> ready_o=0 and data_o held; ready_i=1 -> accept and drain in the same cycle, valid_o stays 1 with new data.
REQ-050 CNT_W=2, four mismatches -> fault_cnt_o saturates at 3; clear_i coincident with a fifth mismatch -> fault_cnt_o=0.
